// File: rtl/spi_counter_slave.sv
// SPI mode-0 slave receiving 2-byte counter frames ({2'b00,cnt[13:8]}, cnt[7:0]).
// Publishes the 14-bit counter and echoes the last received byte on miso.
module spi_counter_slave #(
  parameter int FRAME_TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic        ss,
  output logic [13:0] o_counter,
  output logic        o_valid,
  output logic        o_frame_err
);

  localparam int TW = $clog2(FRAME_TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(FRAME_TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    WAIT_HIGH,
    WAIT_LOW,
    PUBLISH
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sclk_sync_q, sclk_sync_d;
  logic [1:0]    mosi_sync_q, mosi_sync_d;
  logic [1:0]    ss_sync_q, ss_sync_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic [5:0]    hi_q, hi_d;
  logic [13:0]   cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          byte_done_q, byte_done_d;
  logic          shift_pend_q, shift_pend_d;
  logic          err_q, err_d;

  logic ss_hi, rise, fall, sclk_edge, to_active, to_hit;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    ss_sync_d   = {ss_sync_q[0], ss};

    ss_hi     = ss_sync_q[1];
    rise      = ~ss_hi & sclk_sync_q[1] & ~sclk_sync_q[2];
    fall      = ~ss_hi & ~sclk_sync_q[1] & sclk_sync_q[2];
    sclk_edge = rise | fall;
    to_active = (bit_cnt_q != 3'd0) || (state_q == WAIT_LOW);
    // A live sclk edge always beats the terminal count
    to_hit    = ~ss_hi & to_active & (to_q >= TMAX)
              & ~sclk_edge & ~byte_done_q;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    hi_d         = hi_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    byte_done_d  = 1'b0;
    shift_pend_d = shift_pend_q;
    err_d        = 1'b0;

    if (ss_hi || sclk_edge || !to_active) begin
      to_d = '0;
    end else if (to_q != TMAX) begin
      to_d = to_q + TW'(1);
    end

    if (rise) begin
      rx_d         = {rx_q[6:0], mosi_sync_q[1]};
      bit_cnt_d    = bit_cnt_q + 3'd1;
      byte_done_d  = (bit_cnt_q == 3'd7);
      shift_pend_d = (bit_cnt_q != 3'd7);
    end

    if (fall && shift_pend_q) begin
      tx_d         = {tx_q[6:0], 1'b0};
      shift_pend_d = 1'b0;
    end

    if (byte_done_q) begin
      tx_d = rx_q;
    end

    unique case (state_q)
      WAIT_HIGH: begin
        if (byte_done_q) begin
          if (rx_q[7:6] == 2'b00) begin
            hi_d    = rx_q[5:0];
            state_d = WAIT_LOW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_LOW: begin
        if (byte_done_q) begin
          cnt_d   = {hi_q, rx_q};
          state_d = PUBLISH;
        end
      end
      PUBLISH: state_d = WAIT_HIGH;
      default: state_d = WAIT_HIGH;
    endcase

    if (to_hit) begin
      bit_cnt_d    = 3'd0;
      rx_d         = 8'd0;
      shift_pend_d = 1'b0;
      state_d      = WAIT_HIGH;
      err_d        = (state_q != PUBLISH);
    end

    if (ss_hi) begin
      bit_cnt_d    = 3'd0;
      shift_pend_d = 1'b0;
      byte_done_d  = 1'b0;
      err_d        = 1'b0;
      cnt_d        = cnt_q;
      state_d      = WAIT_HIGH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_HIGH;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      ss_sync_q    <= 2'b11;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      hi_q         <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      byte_done_q  <= 1'b0;
      shift_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ss_sync_q    <= ss_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      hi_q         <= hi_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      byte_done_q  <= byte_done_d;
      shift_pend_q <= shift_pend_d;
      err_q        <= err_d;
    end
  end

  assign miso        = ~ss_hi & tx_q[7];
  assign o_counter   = cnt_q;
  assign o_valid     = (state_q == PUBLISH);
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_spi_counter_slave.sv
// Directed bench for spi_counter_slave: frame table plus timeout,
// mid-frame reset and miso echo sequences.
module tb_spi_counter_slave;

  localparam int TO   = 300;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        ss;
  logic [13:0] o_counter;
  logic        o_valid;
  logic        o_frame_err;

  spi_counter_slave #(.FRAME_TIMEOUT_CLKS(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .ss         (ss),
    .o_counter  (o_counter),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vcnt = 0, ecnt = 0, both = 0;
  int valid_cyc = -100, rise_cyc = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_valid) begin
      vcnt++;
      valid_cyc = cyc;
    end
    if (o_frame_err) ecnt++;
    if (o_valid && o_frame_err) both++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits,
                      output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      got[i]   = miso;
      sclk     = 1'b1;
      rise_cyc = cyc;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    bit          two;
    logic [13:0] cnt;
    int          nv;
    int          ne;
    bit          miso_idle;
  } vec_t;

  vec_t v[7];

  initial begin
    static logic [7:0] g;
    static int v0, e0;

    v[0] = '{8'h12, 8'h34, 1'b1, 14'h1234, 1, 0, 1'b0};
    v[1] = '{8'hC1, 8'h00, 1'b0, 14'h1234, 0, 1, 1'b0};
    v[2] = '{8'h05, 8'h67, 1'b1, 14'h0567, 1, 0, 1'b0};
    v[3] = '{8'h3F, 8'hFF, 1'b1, 14'h3FFF, 1, 0, 1'b0};
    v[4] = '{8'h00, 8'h00, 1'b1, 14'h0000, 1, 0, 1'b0};
    v[5] = '{8'h40, 8'h00, 1'b0, 14'h0000, 0, 1, 1'b0};
    v[6] = '{8'h2A, 8'hC3, 1'b1, 14'h2AC3, 1, 0, 1'b0};

    reset = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ss    = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_counter", o_counter, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_frame_err, 0);
    chk("rst_miso", miso, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      ss = 1'b0;
      repeat (4) @(negedge clk);
      v0 = vcnt;
      e0 = ecnt;
      xfer(v[k].hi, 8, g);
      if (v[k].two) begin
        xfer(v[k].lo, 8, g);
        chk($sformatf("v%0d_miso_echo", k), g, v[k].hi);
      end
      repeat (10) @(negedge clk);
      if (v[k].two)
        chk($sformatf("v%0d_latency", k), valid_cyc - rise_cyc, 4);
      ss = 1'b1;
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_counter", k), o_counter, v[k].cnt);
      chk($sformatf("v%0d_nvalid", k), vcnt - v0, v[k].nv);
      chk($sformatf("v%0d_nerr", k), ecnt - e0, v[k].ne);
      chk($sformatf("v%0d_miso_ss", k), miso, 0);
    end

    // partial frame abandoned by timeout
    ss = 1'b0;
    repeat (4) @(negedge clk);
    v0 = vcnt;
    e0 = ecnt;
    xfer(8'h05, 8, g);
    repeat (TO + 10) @(negedge clk);
    chk("to_nerr", ecnt - e0, 1);
    chk("to_nvalid", vcnt - v0, 0);
    chk("to_counter", o_counter, 14'h2AC3);
    xfer(8'h00, 8, g);
    xfer(8'h2A, 8, g);
    repeat (10) @(negedge clk);
    chk("to_next_counter", o_counter, 14'h002A);
    chk("to_next_nvalid", vcnt - v0, 1);
    chk("to_next_nerr", ecnt - e0, 1);
    ss = 1'b1;
    repeat (6) @(negedge clk);

    // reset after 4 bits of the high byte
    ss = 1'b0;
    repeat (4) @(negedge clk);
    v0 = vcnt;
    e0 = ecnt;
    xfer(8'hFF, 4, g);
    reset = 1'b1;
    ss    = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_counter", o_counter, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    xfer(8'h01, 8, g);
    xfer(8'h02, 8, g);
    chk("mid_rst_miso", g, 8'h01);
    repeat (10) @(negedge clk);
    chk("mid_rst_next_counter", o_counter, 14'h0102);
    chk("mid_rst_nvalid", vcnt - v0, 1);
    chk("mid_rst_nerr", ecnt - e0, 0);
    ss = 1'b1;
    repeat (6) @(negedge clk);

    chk("valid_err_overlap", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
